// File: rtl/snn_pkg.sv
// Shared types and reset constants for the spike arbiter block.
// Optional counters are enabled by defining SPIKE_ARB_CNT_EN.
package snn_pkg;

    localparam int unsigned THR_W_DEF = 4;

    // Arbiter sequencing states
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    localparam logic [3:0] THR_RST = 4'b0010;
    localparam logic       WGT_RST = 1'b1;

    // Number of set bits; used to count several drops on one edge
    function automatic int unsigned popcount(input logic [31:0] v);
        int unsigned c;
        c = 0;
        for (int unsigned i = 0; i < 32; i++) c += 32'(v[i]);
        return c;
    endfunction

endpackage

// File: rtl/spike_arbiter_if.sv
// Control, spike-request and neuron-side signals of the spike arbiter.
// spike_cnt/drop_cnt exist only when SPIKE_ARB_CNT_EN is defined.
interface spike_arbiter_if #(
    parameter int unsigned N_IN  = 4,
    parameter int unsigned THR_W = 4
`ifdef SPIKE_ARB_CNT_EN
    , parameter int unsigned CNT_W = 16
`endif
);
    localparam int unsigned IDX_W = $clog2(N_IN);

    logic              start;
    logic              stop;
    logic [N_IN-1:0]   req_spike;
    logic [N_IN-1:0]   req_sign;
    logic              cfg_we;
    logic [THR_W-1:0]  cfg_threshold;
    logic              cfg_weight;
    logic              data_out;
    logic              sign_out;
    logic [IDX_W-1:0]  grant_idx;
    logic [THR_W-1:0]  threshold;
    logic              weight;
    logic              busy;
    logic              overflow;
    logic              cfg_err;
`ifdef SPIKE_ARB_CNT_EN
    logic [CNT_W-1:0]  spike_cnt;
    logic [CNT_W-1:0]  drop_cnt;

    modport master (output start, stop, req_spike, req_sign, cfg_we, cfg_threshold, cfg_weight,
                    input  data_out, sign_out, grant_idx, threshold, weight, busy, overflow, cfg_err,
                           spike_cnt, drop_cnt);
    modport slave  (input  start, stop, req_spike, req_sign, cfg_we, cfg_threshold, cfg_weight,
                    output data_out, sign_out, grant_idx, threshold, weight, busy, overflow, cfg_err,
                           spike_cnt, drop_cnt);
`else
    modport master (output start, stop, req_spike, req_sign, cfg_we, cfg_threshold, cfg_weight,
                    input  data_out, sign_out, grant_idx, threshold, weight, busy, overflow, cfg_err);
    modport slave  (input  start, stop, req_spike, req_sign, cfg_we, cfg_threshold, cfg_weight,
                    output data_out, sign_out, grant_idx, threshold, weight, busy, overflow, cfg_err);
`endif

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first pending source after ptr, wrapping mod N_IN.
module rr_pick #(
    parameter  int unsigned N_IN  = 4,
    localparam int unsigned IDX_W = $clog2(N_IN)
) (
    input  logic [N_IN-1:0]  pending,
    input  logic [IDX_W-1:0] ptr,
    output logic             valid,
    output logic [IDX_W-1:0] idx
);

    logic [IDX_W-1:0] pos;

    // Scan farthest offset first so the nearest pending source after ptr wins
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        pos   = '0;
        for (int unsigned k = N_IN; k >= 1; k--) begin
            pos = IDX_W'((32'(ptr) + k) % N_IN);
            if (pending[pos]) begin
                valid = 1'b1;
                idx   = pos;
            end
        end
    end

endmodule

// File: rtl/spike_arbiter.sv
// Serialises latched per-source spikes round-robin into one neuron input and owns its config.
// Define SPIKE_ARB_CNT_EN to add saturating spike_cnt/drop_cnt outputs.
module spike_arbiter
    import snn_pkg::*;
#(
    parameter int unsigned N_IN  = 4,
    parameter int unsigned THR_W = THR_W_DEF
`ifdef SPIKE_ARB_CNT_EN
    , parameter int unsigned CNT_W = 16
`endif
) (
    input logic            clk,
    input logic            rst,
    spike_arbiter_if.slave bus
);

    localparam int unsigned IDX_W = $clog2(N_IN);

    logic [1:0]       state, state_nxt;
    logic             start_acc;
    logic [N_IN-1:0]  pending, pending_nxt;
    logic [N_IN-1:0]  psign, psign_nxt;
    logic [IDX_W-1:0] ptr;
    logic             pick_valid, grant_ok;
    logic [IDX_W-1:0] pick_idx;
    logic [N_IN-1:0]  grant_mask, cap, drop, keep;

    rr_pick #(.N_IN(N_IN)) u_pick (
        .pending (pending),
        .ptr     (ptr),
        .valid   (pick_valid),
        .idx     (pick_idx)
    );

    // Grant, capture and collision resolution for this edge
    always_comb begin
        grant_ok    = pick_valid && (state != ST_IDLE);
        grant_mask  = grant_ok ? (N_IN'(1) << pick_idx) : '0;
        cap         = (state == ST_RUN) ? bus.req_spike : '0;
        drop        = cap & pending & ~grant_mask;
        keep        = cap & ~drop;
        pending_nxt = (pending & ~grant_mask) | cap;
        psign_nxt   = (psign & ~keep) | (bus.req_sign & keep);
    end

    always_comb begin
        state_nxt = state;
        start_acc = 1'b0;
        case (state)
            ST_IDLE:  if (bus.start) begin
                          state_nxt = ST_RUN;
                          start_acc = 1'b1;
                      end
            ST_RUN:   if (bus.stop) state_nxt = ST_DRAIN;
            ST_DRAIN: if (pending_nxt == '0) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    assign bus.busy = (state != ST_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending       <= '0;
            psign         <= '0;
            ptr           <= IDX_W'(N_IN - 1);
            bus.data_out  <= 1'b0;
            bus.sign_out  <= 1'b0;
            bus.grant_idx <= '0;
            bus.threshold <= THR_W'(THR_RST);
            bus.weight    <= WGT_RST;
            bus.overflow  <= 1'b0;
            bus.cfg_err   <= 1'b0;
        end else begin
            pending      <= pending_nxt;
            psign        <= psign_nxt;
            bus.data_out <= grant_ok;
            bus.sign_out <= grant_ok & psign[pick_idx];
            if (grant_ok) begin
                bus.grant_idx <= pick_idx;
                ptr           <= pick_idx;
            end
            // Config only lands while idle; any other write is flagged and discarded
            if (bus.cfg_we && state == ST_IDLE) begin
                bus.threshold <= bus.cfg_threshold;
                bus.weight    <= bus.cfg_weight;
            end
            bus.cfg_err  <= bus.cfg_we && (state != ST_IDLE);
            bus.overflow <= start_acc ? 1'b0 : (bus.overflow | (|drop));
        end
    end

`ifdef SPIKE_ARB_CNT_EN
    localparam int unsigned CW1 = CNT_W + 1;

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a, input int unsigned b);
        logic [CNT_W:0] s;
        s = {1'b0, a} + CW1'(b);
        return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.spike_cnt <= '0;
            bus.drop_cnt  <= '0;
        end else if (start_acc) begin
            bus.spike_cnt <= '0;
            bus.drop_cnt  <= '0;
        end else begin
            bus.spike_cnt <= sat_add(bus.spike_cnt, grant_ok ? 1 : 0);
            bus.drop_cnt  <= sat_add(bus.drop_cnt, popcount(32'(drop)));
        end
    end
`endif

endmodule

// File: tb/tb_spike_arbiter.sv
// Scoreboard bench for spike_arbiter: a cycle-level reference model queues expected pulses.
// Build with SPIKE_ARB_CNT_EN defined to also check the counters.
module tb_spike_arbiter;

    localparam int N    = 4;
    localparam int CMAX = 65535;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    spike_arbiter_if bus ();

    spike_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int checks   = 0;
    int failures = 0;

    function automatic void chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
        end
    endfunction

    // ---------------- reference model ----------------
    typedef struct { int c; int idx; bit s; } pulse_t;
    pulse_t q[$];
    pulse_t e;

    int cyc = 0;
    int m_mode;                 // 0 idle, 1 run, 2 drain
    bit m_pend[N];
    bit m_sgn[N];
    int m_last, m_gidx, m_thr, m_scnt, m_dcnt;
    bit m_wgt, m_ovf, m_cerr;
    int pulse_seen = 0;

    function automatic void m_reset();
        m_mode = 0; m_last = N - 1; m_gidx = 0; m_thr = 2; m_wgt = 1;
        m_ovf = 0; m_cerr = 0; m_scnt = 0; m_dcnt = 0;
        for (int i = 0; i < N; i++) begin m_pend[i] = 0; m_sgn[i] = 0; end
    endfunction

    always @(posedge clk or posedge rst) begin
        int g, p, mode0;
        bit any;
        if (rst) begin
            m_reset();
            q.delete();
        end else begin
            cyc++;
            mode0 = m_mode;
            g = -1;
            if (mode0 != 0)
                for (int k = 1; k <= N; k++) begin
                    p = (m_last + k) % N;
                    if (g < 0 && m_pend[p]) g = p;
                end
            if (g >= 0) begin
                q.push_back('{cyc, g, m_sgn[g]});
                m_pend[g] = 0; m_last = g; m_gidx = g;
                if (m_scnt < CMAX) m_scnt++;
            end
            if (mode0 == 1)
                for (int i = 0; i < N; i++)
                    if (bus.req_spike[i]) begin
                        if (m_pend[i]) begin
                            m_ovf = 1;
                            if (m_dcnt < CMAX) m_dcnt++;
                        end else begin
                            m_pend[i] = 1; m_sgn[i] = bus.req_sign[i];
                        end
                    end
            m_cerr = bus.cfg_we && mode0 != 0;
            if (bus.cfg_we && mode0 == 0) begin m_thr = bus.cfg_threshold; m_wgt = bus.cfg_weight; end
            any = 0;
            for (int i = 0; i < N; i++) any |= m_pend[i];
            if (mode0 == 0 && bus.start) begin m_mode = 1; m_ovf = 0; m_scnt = 0; m_dcnt = 0; end
            else if (mode0 == 1 && bus.stop) m_mode = 2;
            else if (mode0 == 2 && !any) m_mode = 0;
        end
    end

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (bus.data_out) begin
            pulse_seen++;
            if (q.size() == 0) begin
                failures++; checks++;
                $display("FAIL pulse_unexpected actual_idx=%0d expected=none t=%0t", bus.grant_idx, $time);
            end else begin
                e = q.pop_front();
                chk("pulse_cycle", cyc, e.c);
                chk("pulse_idx", int'(bus.grant_idx), e.idx);
                chk("pulse_sign", int'(bus.sign_out), int'(e.s));
            end
        end else begin
            chk("sign_idle", int'(bus.sign_out), 0);
            if (q.size() > 0 && q[0].c <= cyc) begin
                e = q.pop_front();
                failures++; checks++;
                $display("FAIL pulse_missing actual=none expected_idx=%0d t=%0t", e.idx, $time);
            end
        end
        chk("grant_idx_hold", int'(bus.grant_idx), m_gidx);
        chk("busy", int'(bus.busy), int'(m_mode != 0));
        chk("overflow", int'(bus.overflow), int'(m_ovf));
        chk("threshold", int'(bus.threshold), m_thr);
        chk("weight", int'(bus.weight), int'(m_wgt));
        chk("cfg_err", int'(bus.cfg_err), int'(m_cerr));
`ifdef SPIKE_ARB_CNT_EN
        chk("spike_cnt", int'(bus.spike_cnt), m_scnt);
        chk("drop_cnt", int'(bus.drop_cnt), m_dcnt);
`endif
    end

    // ---------------- stimulus ----------------
    task automatic drive(input bit st, input bit sp, input logic [N-1:0] rq, input logic [N-1:0] rs,
                         input bit we, input logic [3:0] thr, input bit w);
        bus.start = st; bus.stop = sp; bus.req_spike = rq; bus.req_sign = rs;
        bus.cfg_we = we; bus.cfg_threshold = thr; bus.cfg_weight = w;
        @(posedge clk); #1;
        bus.start = 0; bus.stop = 0; bus.req_spike = '0; bus.req_sign = '0;
        bus.cfg_we = 0; bus.cfg_threshold = '0; bus.cfg_weight = 0;
    endtask

    task automatic expect_pulse(input int idx, input int s);
        @(negedge clk);
        chk("dir_data", int'(bus.data_out), 1);
        chk("dir_idx", int'(bus.grant_idx), idx);
        chk("dir_sign", int'(bus.sign_out), s);
    endtask

    task automatic expect_none();
        @(negedge clk);
        chk("dir_quiet", int'(bus.data_out), 0);
    endtask

    initial begin
        int p0;
        m_reset();
        bus.start = 0; bus.stop = 0; bus.req_spike = '0; bus.req_sign = '0;
        bus.cfg_we = 0; bus.cfg_threshold = '0; bus.cfg_weight = 0;
        repeat (2) @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        chk("rst_threshold", int'(bus.threshold), 2);
        chk("rst_weight", int'(bus.weight), 1);
        chk("rst_busy", int'(bus.busy), 0);

        // config in IDLE then rejected write in RUN
        drive(0, 0, '0, '0, 1, 4'd5, 0);
        @(negedge clk);
        chk("cfg_thr", int'(bus.threshold), 5);
        chk("cfg_wgt", int'(bus.weight), 0);
        drive(1, 0, '0, '0, 0, 4'd0, 0);
        drive(0, 0, '0, '0, 1, 4'd9, 1);
        @(negedge clk);
        chk("cfg_err_pulse", int'(bus.cfg_err), 1);
        chk("cfg_thr_kept", int'(bus.threshold), 5);
        @(negedge clk);
        chk("cfg_err_clear", int'(bus.cfg_err), 0);

        // fairness from a fresh pointer
        drive(0, 0, 4'b1111, 4'b1010, 0, 4'd0, 0);
        expect_none();
        expect_pulse(0, 0); expect_pulse(1, 1); expect_pulse(2, 0); expect_pulse(3, 1);
        drive(0, 0, 4'b1001, 4'b0001, 0, 4'd0, 0);
        expect_none();
        expect_pulse(0, 1); expect_pulse(3, 0);

        // single spike latency
        drive(0, 0, 4'b0100, 4'b0100, 0, 4'd0, 0);
        expect_none();
        expect_pulse(2, 1);
        expect_none();

        // collision: second req[1] dropped while src 0 is granted
        drive(0, 0, 4'b0011, 4'b0000, 0, 4'd0, 0);
        drive(0, 0, 4'b0010, 4'b0010, 0, 4'd0, 0);
        @(negedge clk);
        chk("coll_overflow", int'(bus.overflow), 1);
        repeat (3) drive(0, 0, '0, '0, 0, 4'd0, 0);
        // same-edge regrant keeps both spikes from source 1
        drive(0, 0, 4'b0010, 4'b0010, 0, 4'd0, 0);
        drive(0, 0, 4'b0010, 4'b0000, 0, 4'd0, 0);
        expect_pulse(1, 1); expect_pulse(1, 0);
        expect_none();

        // async reset with spikes in flight
        drive(0, 0, 4'b0111, 4'b0101, 0, 4'd0, 0);
        rst = 1;
        @(negedge clk);
        chk("rst_data", int'(bus.data_out), 0);
        chk("rst_busy2", int'(bus.busy), 0);
        chk("rst_thr2", int'(bus.threshold), 2);
        chk("rst_ovf", int'(bus.overflow), 0);
        @(posedge clk); #1 rst = 0;

        // drain: three pending, stop, ignored requests during drain
        drive(1, 0, '0, '0, 0, 4'd0, 0);
        p0 = pulse_seen;
        drive(0, 0, 4'b0111, 4'b0010, 0, 4'd0, 0);
        drive(0, 1, '0, '0, 0, 4'd0, 0);
        drive(0, 0, 4'b1111, 4'b1111, 0, 4'd0, 0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (!bus.busy) break;
        end
        #1;
        chk("drain_busy_fall", int'(bus.busy), 0);
        chk("drain_pulses", pulse_seen - p0, 3);
`ifdef SPIKE_ARB_CNT_EN
        chk("drain_spike_cnt", int'(bus.spike_cnt), 3);
`endif

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(0, 599) == 0);
            bus.start = ($urandom_range(0, 15) == 0);
            bus.stop  = ($urandom_range(0, 39) == 0);
            bus.req_spike = ($urandom_range(0, 7) == 0) ? 4'b1111 : 4'($urandom & $urandom);
            bus.req_sign  = 4'($urandom);
            bus.cfg_we = ($urandom_range(0, 9) == 0);
            bus.cfg_threshold = 4'($urandom);
            bus.cfg_weight = 1'($urandom);
            @(posedge clk); #1;
        end
        rst = 0;
        bus.start = 0; bus.req_spike = '0; bus.cfg_we = 0;
        drive(0, 1, '0, '0, 0, 4'd0, 0);
        repeat (20) @(posedge clk);
        @(negedge clk);
        chk("queue_empty", q.size(), 0);
        chk("end_idle", int'(bus.busy), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
